i2s_tx_serializer: RTL and testbench

- Output stage directly downstream of the audio sample rate converter.
- Accepts its 32-bit sign-extended PCM words, alternating left then right, into a small tagged FIFO.
- Generates master-mode I2S BCLK/LRCLK from the system clock and shifts 24-bit samples out MSB-first in 32-bit slots.
- Drives the codec pins and flags underruns to the audio control block.

---
 rtl/i2s_tx_serializer.sv | 191 +++++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: master-mode I2S transmitter fed by a small L/R-tagged FIFO.
// Generates BCLK/LRCLK from clk and flags any slot that starts without its sample.
module i2s_tx_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_DIV   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [31:0]                 pcm_din,
    input  logic                        pcm_din_valid,
    output logic                        pcm_din_ready,
    output logic                        i2s_bclk,
    output logic                        i2s_lrclk,
    output logic                        i2s_sdata,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(SLOT_WIDTH);
    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int EW = DATA_WIDTH + 1;

    localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_WIDTH - 1);
    localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_q, wr_d;
    logic [AW-1:0]         rd_q, rd_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  wtag_q, wtag_d;
    logic [CW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  bclk_q, bclk_d;
    logic                  lr_q, lr_d;
    logic                  sd_q, sd_d;
    logic                  und_q, und_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;

    logic          flush;
    logic          push;
    logic          pop;
    logic          load;
    logic          load_ch;
    logic [EW-1:0] head;
    logic          unused_hi;

    assign flush         = rst || !enable;
    assign pcm_din_ready = (state_q != IDLE) && (level_q != FULL);
    assign push          = pcm_din_valid && pcm_din_ready && !flush;
    assign head          = mem_q[rd_q];
    assign unused_hi     = ^pcm_din[31:DATA_WIDTH];

    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lr_q;
    assign i2s_sdata  = sd_q;
    assign underrun   = und_q;
    assign fifo_level = level_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        bclk_d  = bclk_q;
        lr_d    = lr_q;
        sd_d    = sd_q;
        sh_d    = sh_q;
        und_d   = 1'b0;
        pop     = 1'b0;
        load    = 1'b0;
        load_ch = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = PRIME;
            end
            PRIME: begin
                if (level_q >= LW'(2)) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    // bclk_q high here means this toggle is a falling edge
                    if (bclk_q) begin
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            lr_d    = ~lr_q;
                            sd_d    = 1'b0;
                            load    = 1'b1;
                            load_ch = ~lr_q;
                        end else begin
                            bit_d = bit_q + BW'(1);
                            sd_d  = sh_q[DATA_WIDTH-1];
                            sh_d  = sh_q << 1;
                        end
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A mismatched head stays queued so the pair realigns on its own slot
        if (load) begin
            if (level_q != '0 && head[DATA_WIDTH] == load_ch) begin
                pop  = 1'b1;
                sh_d = head[DATA_WIDTH-1:0];
            end else begin
                sh_d  = '0;
                und_d = 1'b1;
            end
        end

        wr_d   = wr_q + AW'(push);
        rd_d   = rd_q + AW'(pop);
        wtag_d = wtag_q ^ push;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (flush) begin
            state_d = IDLE;
            div_d   = '0;
            bit_d   = '0;
            bclk_d  = 1'b0;
            lr_d    = 1'b0;
            sd_d    = 1'b0;
            sh_d    = '0;
            und_d   = 1'b0;
            pop     = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            wtag_d  = 1'b0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            wtag_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            bclk_q  <= 1'b0;
            lr_q    <= 1'b0;
            sd_q    <= 1'b0;
            und_q   <= 1'b0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            wtag_q  <= wtag_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            bclk_q  <= bclk_d;
            lr_q    <= lr_d;
            sd_q    <= sd_d;
            und_q   <= und_d;
            sh_q    <= sh_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {wtag_q, pcm_din[DATA_WIDTH-1:0]};
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: a slot deserializer monitor checks every completed
// slot against a queue of expected {underrun, channel, sample} entries.
module tb_i2s_tx_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] din = '0;
    logic        ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;
    logic [3:0]  level;

    int total = 0;
    int bad = 0;
    bit full_watch = 0;
    logic [25:0] expq[$];

    logic [31:0] bp [12] = '{
        32'h00123456, 32'hFF876543, 32'h000ABCDE, 32'hFFF00FF0,
        32'h00700001, 32'hFF800000, 32'h007FFFFF, 32'h00000001,
        32'hFFDEAD01, 32'hFFBEEF02, 32'h00135790, 32'h002468AC
    };

    always #5 clk = ~clk;

    i2s_tx_serializer #(
        .DATA_WIDTH(24),
        .SLOT_WIDTH(32),
        .FIFO_DEPTH(8),
        .BCLK_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .pcm_din(din),
        .pcm_din_valid(valid),
        .pcm_din_ready(ready),
        .i2s_bclk(bclk),
        .i2s_lrclk(lrclk),
        .i2s_sdata(sdata),
        .underrun(underrun),
        .fifo_level(level)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic expect_slot(input bit ch, input bit und,
                               input logic [23:0] d);
        expq.push_back({und, ch, d});
    endtask

    // Call at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [31:0] w);
        int n = 0;
        valid = 1'b1;
        din   = w;
        while (!ready && n < 2000) begin
            if (full_watch) begin
                chk("ready_drop_level", 32'(level), 32'd8);
                full_watch = 0;
            end
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout got=ready0 want=ready1");
        end
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while (expq.size() != 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=%0d_pending want=0", nm, expq.size());
            expq.delete();
        end
    endtask

    initial begin : monitor
        bit          prev_b = 0;
        bit          in_slot = 0;
        bit          cur_ch = 0;
        bit          pad_ok = 1;
        int          idx = 0;
        int          und_pend = 0;
        int          slot_und = 0;
        logic [23:0] data = '0;
        logic [25:0] e;
        forever begin
            @(negedge clk);
            if (rst || !enable) begin
                in_slot  = 0;
                idx      = 0;
                prev_b   = 0;
                und_pend = 0;
            end else begin
                if (underrun) und_pend++;
                if (bclk && !prev_b) begin
                    if (!in_slot || lrclk != cur_ch) begin
                        in_slot  = 1;
                        cur_ch   = lrclk;
                        idx      = 0;
                        data     = '0;
                        pad_ok   = (sdata == 1'b0);
                        slot_und = und_pend;
                        und_pend = 0;
                    end else begin
                        idx++;
                        if (idx <= 24) data = {data[22:0], sdata};
                        else if (sdata) pad_ok = 0;
                    end
                    if (idx == 31) begin
                        if (expq.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL extra_slot got=ch%0d_%h want=none",
                                     cur_ch, data);
                        end else begin
                            e = expq.pop_front();
                            chk("slot", {4'(slot_und), pad_ok, 2'b0, cur_ch, data},
                                {4'(e[25]), 1'b1, 2'b0, e[24], e[23:0]});
                        end
                    end
                end
                prev_b = bclk;
            end
        end
    end

    initial begin : stim
        int n;
        int rises;
        bit pb;

        // reset and idle
        valid = 1'b1;
        din   = 32'h12345678;
        repeat (3) @(negedge clk);
        chk("rst_pins", {28'd0, bclk, lrclk, sdata, underrun}, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_ready", 32'(ready), 32'd0);
        valid = 1'b0;

        // basic frame followed by an underrun frame
        expect_slot(0, 0, 24'hA5A5A5);
        expect_slot(1, 0, 24'h5A5A5A);
        expect_slot(0, 1, 24'h000000);
        expect_slot(1, 1, 24'h000000);
        enable = 1'b1;
        @(negedge clk);
        push(32'hFFA5A5A5);
        push(32'h005A5A5A);
        n = 0;
        while (level != 4'd1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("run_entry_level", 32'(level), 32'd1);
        n = 0;
        while (!lrclk && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("lr_rise_delay", n, 128);
        n = 0;
        while (lrclk && n < 1000) begin
            @(negedge clk);
            n++;
        end
        while (!lrclk && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_period", n, 256);
        wait_empty("basic");
        enable = 1'b0;
        @(negedge clk);

        // backpressure: 12 words through an 8-deep FIFO
        for (int i = 0; i < 12; i++) expect_slot(i[0], 0, bp[i][23:0]);
        enable = 1'b1;
        @(negedge clk);
        full_watch = 1;
        for (int i = 0; i < 12; i++) push(bp[i]);
        chk("full_reached", 32'(full_watch), 32'd0);
        full_watch = 0;
        wait_empty("backpressure");
        enable = 1'b0;
        @(negedge clk);

        // resync after left-slot underrun
        expect_slot(0, 0, 24'h111111);
        expect_slot(1, 0, 24'h222222);
        expect_slot(0, 1, 24'h000000);
        expect_slot(1, 1, 24'h000000);
        expect_slot(0, 0, 24'h333333);
        expect_slot(1, 0, 24'h444444);
        enable = 1'b1;
        @(negedge clk);
        push(32'h00111111);
        push(32'h00222222);
        n = 0;
        while (!underrun && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("underrun_seen", 32'(underrun), 32'd1);
        push(32'h00333333);
        push(32'h00444444);
        wait_empty("resync");
        enable = 1'b0;
        @(negedge clk);

        // disable mid-slot at bit 10
        enable = 1'b1;
        @(negedge clk);
        push(32'hFFAAAAAA);
        push(32'h00555555);
        push(32'hFFCCCCCC);
        rises = 0;
        pb    = 0;
        n     = 0;
        while (rises < 11 && n < 1000) begin
            if (bclk && !pb) rises++;
            pb = bclk;
            if (rises < 11) @(negedge clk);
            n++;
        end
        chk("bit10_reached", rises, 11);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_pins", {28'd0, bclk, lrclk, sdata, underrun}, 32'd0);
        chk("dis_level", 32'(level), 32'd0);
        chk("dis_ready", 32'(ready), 32'd0);
        @(negedge clk);
        expect_slot(0, 0, 24'h012345);
        expect_slot(1, 0, 24'h9ABCDE);
        enable = 1'b1;
        @(negedge clk);
        push(32'h00012345);
        push(32'hFF9ABCDE);
        wait_empty("reenable");
        enable = 1'b0;
        @(negedge clk);

        // reset mid-stream, then stay disabled
        enable = 1'b1;
        @(negedge clk);
        push(32'h00777777);
        push(32'h00666666);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_pins", {28'd0, bclk, lrclk, sdata, underrun}, 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        rst    = 1'b0;
        valid  = 1'b1;
        din    = 32'h00ABCDEF;
        repeat (4) @(negedge clk);
        chk("off_level", 32'(level), 32'd0);
        chk("off_ready", 32'(ready), 32'd0);
        valid = 1'b0;
        chk("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
